// File: rtl/hop_sequencer.sv
// Timed phase-hop controller: plays a programmable (phase, dwell) table out as an
// AXI-Stream of phase beats at the programmed dwell instants.
module hop_sequencer #(
  parameter int TABLE_DEPTH = 16,
  parameter int PHASE_W     = 32,
  parameter int DWELL_W     = 32,
  parameter int MIN_DWELL   = 2,
  localparam int AW         = $clog2(TABLE_DEPTH)
) (
  input  logic               axis_data_clk,
  input  logic               axis_data_rst,
  input  logic               cfg_wr_en,
  input  logic [AW-1:0]      cfg_wr_addr,
  input  logic [PHASE_W-1:0] cfg_wr_phase,
  input  logic [DWELL_W-1:0] cfg_wr_dwell,
  input  logic [AW:0]        cfg_num_entries,
  input  logic [15:0]        cfg_num_passes,
  input  logic               cmd_start,
  input  logic               cmd_stop,
  output logic [PHASE_W-1:0] m_phase_tdata,
  output logic               m_phase_tvalid,
  input  logic               m_phase_tready,
  output logic               m_phase_tlast,
  output logic               busy,
  output logic               done,
  output logic               err_overrun,
  output logic               err_cfg,
  output logic [31:0]        hop_count
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  localparam logic [AW:0] DEPTH_N = (AW+1)'(TABLE_DEPTH);

  logic [PHASE_W-1:0] phase_mem [TABLE_DEPTH];
  logic [DWELL_W-1:0] dwell_mem [TABLE_DEPTH];

  state_t             state;
  logic [AW-1:0]      idx;
  logic [15:0]        pass;
  logic [DWELL_W-1:0] cnt;
  logic [AW:0]        num_ent;
  logic [15:0]        num_pass;
  logic               done_pend;

  logic [AW-1:0] nxt_idx;
  logic          wrap, nxt_last, last_pass, due, pending, accept, cfg_ok;

  function automatic logic [DWELL_W-1:0] clamp_dwell(input logic [DWELL_W-1:0] d);
    if (d < DWELL_W'(MIN_DWELL)) return DWELL_W'(MIN_DWELL);
    return d;
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] c);
    if (c == 32'hFFFF_FFFF) return c;
    return c + 32'd1;
  endfunction

  // Table has no reset so contents survive a block reset.
  always_ff @(posedge axis_data_clk) begin
    if (cfg_wr_en) begin
      phase_mem[cfg_wr_addr] <= cfg_wr_phase;
      dwell_mem[cfg_wr_addr] <= cfg_wr_dwell;
    end
  end

  assign wrap      = ({1'b0, idx} == num_ent - 1'b1);
  assign nxt_idx   = wrap ? '0 : idx + 1'b1;
  assign nxt_last  = ({1'b0, nxt_idx} == num_ent - 1'b1);
  assign last_pass = (num_pass != 16'd0) && (pass == num_pass - 16'd1);
  assign due       = (cnt == DWELL_W'(1));
  assign pending   = m_phase_tvalid && !m_phase_tready;
  assign accept    = m_phase_tvalid && m_phase_tready;
  assign cfg_ok    = (cfg_num_entries != '0) && (cfg_num_entries <= DEPTH_N);

  always_ff @(posedge axis_data_clk) begin
    if (axis_data_rst) begin
      state          <= IDLE;
      busy           <= 1'b0;
      done           <= 1'b0;
      done_pend      <= 1'b0;
      m_phase_tvalid <= 1'b0;
      m_phase_tlast  <= 1'b0;
      m_phase_tdata  <= '0;
      err_overrun    <= 1'b0;
      err_cfg        <= 1'b0;
      hop_count      <= '0;
      idx            <= '0;
      pass           <= '0;
      cnt            <= '0;
      num_ent        <= '0;
      num_pass       <= '0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        hop_count      <= sat_inc(hop_count);
        m_phase_tvalid <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (done_pend) begin
            done      <= 1'b1;
            done_pend <= 1'b0;
          end
          if (cmd_start && !cmd_stop) begin
            if (cfg_ok) begin
              num_ent        <= cfg_num_entries;
              num_pass       <= cfg_num_passes;
              err_overrun    <= 1'b0;
              err_cfg        <= 1'b0;
              hop_count      <= '0;
              idx            <= '0;
              pass           <= '0;
              cnt            <= clamp_dwell(dwell_mem[0]);
              m_phase_tvalid <= 1'b1;
              m_phase_tdata  <= phase_mem[0];
              m_phase_tlast  <= (cfg_num_entries == (AW+1)'(1));
              busy           <= 1'b1;
              state          <= RUN;
            end else begin
              err_cfg <= 1'b1;
            end
          end
        end
        RUN: begin
          // Stop outranks a hop falling due in the same cycle.
          if (cmd_stop || (due && wrap && last_pass)) begin
            if (pending) begin
              state <= DRAIN;
            end else begin
              state     <= IDLE;
              busy      <= 1'b0;
              done_pend <= 1'b1;
            end
          end else if (due) begin
            idx <= nxt_idx;
            cnt <= clamp_dwell(dwell_mem[nxt_idx]);
            if (wrap) pass <= pass + 16'd1;
            if (pending) begin
              err_overrun <= 1'b1;
            end else begin
              m_phase_tvalid <= 1'b1;
              m_phase_tdata  <= phase_mem[nxt_idx];
              m_phase_tlast  <= nxt_last;
            end
          end else begin
            cnt <= cnt - DWELL_W'(1);
          end
        end
        DRAIN: begin
          if (m_phase_tready) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hop_sequencer.sv
// Bench for hop_sequencer: directed scenarios plus a randomized run, all checked
// cycle by cycle against a timestamp-based reference model.
module tb_hop_sequencer;
  localparam int DEPTH = 16;
  localparam int MIND  = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [31:0] wr_phase, wr_dwell;
  logic [4:0]  num_entries;
  logic [15:0] num_passes;
  logic        start, stop, tready;
  logic [31:0] tdata;
  logic        tvalid, tlast, busy, done, err_overrun, err_cfg;
  logic [31:0] hop_count;

  always #5 clk = ~clk;

  hop_sequencer #(.TABLE_DEPTH(DEPTH), .PHASE_W(32), .DWELL_W(32), .MIN_DWELL(MIND)) dut (
    .axis_data_clk(clk), .axis_data_rst(rst),
    .cfg_wr_en(wr_en), .cfg_wr_addr(wr_addr), .cfg_wr_phase(wr_phase), .cfg_wr_dwell(wr_dwell),
    .cfg_num_entries(num_entries), .cfg_num_passes(num_passes),
    .cmd_start(start), .cmd_stop(stop),
    .m_phase_tdata(tdata), .m_phase_tvalid(tvalid), .m_phase_tready(tready), .m_phase_tlast(tlast),
    .busy(busy), .done(done), .err_overrun(err_overrun), .err_cfg(err_cfg), .hop_count(hop_count)
  );

  int checks = 0, passed = 0, fails = 0;

  // Reference model: absolute cycle stamps and a global hop number k.
  logic [31:0] mphase [DEPTH];
  logic [31:0] mdw    [DEPTH];
  int          mstate = 0;
  logic        mvalid = 0, mlast = 0, mbusy = 0, mdone = 0, mov = 0, mcfg = 0;
  logic [31:0] mdata = 0, mhops = 0;
  longint      t = 0, due_at = 0, done_at = -1;
  int          k = 0, n = 1, passes = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] deff(input logic [31:0] d);
    return (d < 32'(MIND)) ? 32'(MIND) : d;
  endfunction

  function automatic logic [127:0] dut_vec();
    return {58'd0, tvalid ? tdata : 32'd0, tvalid, tvalid & tlast, busy, done,
            err_overrun, err_cfg, hop_count};
  endfunction

  function automatic logic [127:0] model_vec();
    return {58'd0, mvalid ? mdata : 32'd0, mvalid, mvalid & mlast, mbusy, mdone,
            mov, mcfg, mhops};
  endfunction

  task automatic present(input int e);
    mvalid = 1'b1;
    mdata  = mphase[e];
    mlast  = (e == n - 1);
  endtask

  task automatic model_edge();
    logic acc, pend;
    int   e;
    acc  = mvalid && tready;
    pend = mvalid && !tready;
    t++;
    if (rst) begin
      mstate = 0; mvalid = 0; mlast = 0; mdata = 0; mbusy = 0;
      mov = 0; mcfg = 0; mhops = 0; done_at = -1;
    end else begin
      if (acc) begin
        if (mhops != 32'hFFFF_FFFF) mhops++;
        mvalid = 1'b0;
      end
      if (mstate == 0) begin
        if (start && !stop) begin
          if (num_entries >= 1 && num_entries <= DEPTH) begin
            n = int'(num_entries); passes = int'(num_passes);
            mov = 0; mcfg = 0; mhops = 0; k = 0;
            mstate = 1; mbusy = 1;
            present(0);
            due_at = t + longint'(deff(mdw[0]));
          end else mcfg = 1;
        end
      end else if (mstate == 1) begin
        if (stop || (t == due_at && passes != 0 && k + 1 == n * passes)) begin
          if (pend) mstate = 2;
          else begin mstate = 0; mbusy = 0; done_at = t + 1; end
        end else if (t == due_at) begin
          k++;
          e = k % n;
          due_at = due_at + longint'(deff(mdw[e]));
          if (pend) mov = 1;
          else present(e);
        end
      end else begin
        if (tready) begin mstate = 0; mbusy = 0; mvalid = 0; done_at = t; end
      end
    end
    if (wr_en) begin mphase[wr_addr] = wr_phase; mdw[wr_addr] = wr_dwell; end
    mdone = (t == done_at);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("cycle", dut_vec(), model_vec());
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] ph, input logic [31:0] dw);
    wr_en = 1; wr_addr = a; wr_phase = ph; wr_dwell = dw;
    tick();
    wr_en = 0;
  endtask

  task automatic pulse_start(input logic [4:0] ne, input logic [15:0] np);
    num_entries = ne; num_passes = np; start = 1;
    tick();
    start = 0;
  endtask

  task automatic wait_idle(input int limit);
    for (int i = 0; i < limit; i++) begin
      if (!busy) break;
      tick();
    end
    chk("wait_idle_busy", {127'd0, busy}, 128'd0);
    tick(); tick();
  endtask

  int          nb, done_off, stray;
  int          boff [8];
  logic [31:0] bdat [8];
  logic        blst [8];

  task automatic clear_rec();
    nb = 0; done_off = -1;
    for (int i = 0; i < 8; i++) begin boff[i] = 0; bdat[i] = 0; blst[i] = 0; end
  endtask

  task automatic record(input int j);
    if (tvalid && tready && nb < 8) begin
      boff[nb] = j; bdat[nb] = tdata; blst[nb] = tlast; nb++;
    end
    if (done) done_off = j;
  endtask

  initial begin
    rst = 1; wr_en = 0; wr_addr = 0; wr_phase = 0; wr_dwell = 0;
    num_entries = 0; num_passes = 0; start = 0; stop = 0; tready = 1;
    tick(); tick(); tick();
    rst = 0;
    tick();
    chk("reset_state", dut_vec(), 128'd0);

    for (int i = 0; i < DEPTH; i++) wr(4'(i), 32'h1000 + 32'(i), 32'(i % 5));
    wr(0, 32'h100, 4); wr(1, 32'h200, 4); wr(2, 32'h300, 4);

    // Basic timing: beats at T+1, T+5, T+9, done at T+14
    clear_rec();
    pulse_start(3, 1);
    for (int j = 1; j <= 20; j++) begin
      if (j > 1) tick();
      record(j);
    end
    chk("basic_nbeats", 128'(nb), 128'd3);
    chk("basic_offsets", {32'(boff[0]), 32'(boff[1]), 32'(boff[2])}, {32'd1, 32'd5, 32'd9});
    chk("basic_data", {bdat[0], bdat[1], bdat[2]}, {32'h100, 32'h200, 32'h300});
    chk("basic_tlast", {blst[0], blst[1], blst[2]}, 128'b001);
    chk("basic_done", 128'(done_off), 128'd14);
    chk("basic_hops", 128'(hop_count), 128'd3);

    // MIN_DWELL clamp
    wr(0, 32'h11, 0); wr(1, 32'h22, 1);
    clear_rec();
    pulse_start(2, 2);
    for (int j = 1; j <= 12; j++) begin
      if (j > 1) tick();
      record(j);
    end
    chk("clamp_nbeats", 128'(nb), 128'd4);
    chk("clamp_spacing", {32'(boff[1] - boff[0]), 32'(boff[2] - boff[1]), 32'(boff[3] - boff[2])},
        {32'd2, 32'd2, 32'd2});

    // Backpressure: 0x200 skipped while 0x100 is held
    wr(0, 32'h100, 3); wr(1, 32'h200, 3); wr(2, 32'h300, 3);
    clear_rec();
    tready = 0;
    pulse_start(3, 1);
    for (int j = 1; j <= 16; j++) begin
      if (j > 1) tick();
      if (j <= 5) chk("bp_hold", {tvalid, tdata}, {1'b1, 32'h100});
      if (j == 5) tready = 1;
      record(j);
    end
    chk("bp_data", {32'(nb), bdat[0], bdat[1]}, {32'd2, 32'h100, 32'h300});
    chk("bp_overrun", {127'd0, err_overrun}, 128'd1);
    chk("bp_hops", 128'(hop_count), 128'd2);

    // Stop while a beat is pending -> DRAIN
    wr(0, 32'h5A0, 5); wr(1, 32'h5B0, 5);
    tready = 0;
    pulse_start(2, 0);
    tick(); tick();
    stop = 1; tick(); stop = 0;
    chk("drain_hold", {busy, tvalid, tdata}, {1'b1, 1'b1, 32'h5A0});
    tick(); tick(); tick();
    chk("drain_wait", {busy, tvalid, done, err_overrun}, 128'b1100);
    tready = 1;
    tick();
    chk("drain_done", {busy, tvalid, done}, 128'b001);
    stray = 0;
    for (int j = 0; j < 10; j++) begin tick(); if (tvalid) stray++; end
    chk("drain_no_more", 128'(stray), 128'd0);
    chk("drain_hops", 128'(hop_count), 128'd1);

    // Bad configuration
    pulse_start(0, 1);
    chk("cfg_zero", {err_cfg, busy}, 128'b10);
    pulse_start(3, 1);
    chk("cfg_cleared", {err_cfg, busy}, 128'b01);
    wait_idle(40);
    pulse_start(17, 1);
    chk("cfg_17", {err_cfg, busy}, 128'b10);
    num_entries = 3; start = 1; stop = 1; tick(); start = 0; stop = 0;
    chk("start_stop_idle", {err_cfg, busy}, 128'b10);

    // Live rewrite and wrap
    wr(0, 32'h1A0, 6); wr(1, 32'h1B0, 6);
    clear_rec();
    pulse_start(2, 0);
    tick();
    wr(0, 32'hABC, 6);
    for (int j = 4; j <= 30; j++) begin tick(); record(j); end
    chk("rewrite_data", {bdat[0], bdat[1], bdat[2], bdat[3]}, {32'h1B0, 32'hABC, 32'h1B0, 32'hABC});
    chk("rewrite_tlast", {blst[0], blst[1], blst[2], blst[3]}, 128'b1010);
    stop = 1; tick(); stop = 0;
    wait_idle(20);

    // Reset mid-run drops the pending beat; table survives
    tready = 0;
    pulse_start(3, 0);
    tick(); tick();
    rst = 1; tick(); rst = 0;
    chk("rst_midrun", dut_vec(), 128'd0);
    tready = 1;
    pulse_start(1, 1);
    chk("table_kept", {tvalid, tlast, tdata}, {1'b1, 1'b1, 32'hABC});
    wait_idle(20);

    // Randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      rst         = ($urandom_range(0, 399) == 0);
      tready      = ($urandom_range(0, 3) != 0);
      wr_en       = ($urandom_range(0, 7) == 0);
      wr_addr     = 4'($urandom);
      wr_phase    = $urandom;
      wr_dwell    = 32'($urandom_range(0, 7));
      start       = ($urandom_range(0, 19) == 0);
      stop        = ($urandom_range(0, 59) == 0);
      num_entries = 5'($urandom_range(0, 17));
      num_passes  = 16'($urandom_range(0, 3));
      tick();
    end
    rst = 0; wr_en = 0; start = 0; stop = 0; tready = 1;
    tick(); tick();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
